accumulator_drain: RTL and testbench

Drains finished rows from the accumulator, removes the 32-lane diagonal skew, applies shift/ReLU/int8 saturation, and writes aligned rows into the unified buffer. It sits directly downstream of the accumulator: it drives the accumulator read port (`port1_rd_en_i` / `addr_rd_i`) and consumes `data_o[32]`. The control FSM issues one drain command per tile: base row, row count, destination address and activation settings.

---
 rtl/accumulator_drain.sv | 153 +++++++++++++++
 tb/tb_accumulator_drain.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_drain.sv
// Drains finished accumulator rows, removes the per-lane diagonal skew, quantizes each
// lane to int8 (shift, optional ReLU, saturate) and writes aligned rows to the unified buffer.
module accumulator_drain #(
  parameter int UB_ADDR_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [6:0]            acc_base_i,
  input  logic [7:0]            row_count_i,
  input  logic [UB_ADDR_W-1:0]  ub_base_i,
  input  logic [4:0]            shift_i,
  input  logic                  relu_en_i,
  input  logic [31:0][31:0]     acc_data_i,
  output logic                  acc_rd_en_o,
  output logic [6:0]            acc_addr_rd_o,
  output logic                  ub_wr_en_o,
  output logic [UB_ADDR_W-1:0]  ub_addr_o,
  output logic [31:0][7:0]      ub_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [7:0]           r_count;
  logic [UB_ADDR_W-1:0] r_ub_ptr;
  logic [4:0]           r_shift;
  logic                 r_relu;
  logic                 r_rd_en;
  logic [6:0]           r_rd_addr;
  logic                 r_wr_en;
  logic [UB_ADDR_W-1:0] r_ub_addr;
  logic [31:0][7:0]     r_ub_data;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_last_rd;
  logic                 w_row_valid;
  logic [31:0]          w_aligned [32];
  logic [7:0]           w_quant [32];

  function automatic logic [7:0] quant(input logic [31:0] v, input logic [4:0] sh,
                                       input logic relu);
    logic signed [31:0] s;
    s = $signed(v) >>> sh;
    if (relu && s[31]) s = '0;
    if (s > 32'sd127) return 8'h7f;
    if (s < -32'sd128) return 8'h80;
    return s[7:0];
  endfunction

  // The read counter doubles as the skew-free row index: aligned row = r_cnt - 31.
  assign w_last_rd   = ({1'b0, r_cnt} == ({1'b0, r_count} + 9'd30));
  assign w_row_valid = (r_state == S_READ) && (r_cnt >= 8'd31);

  for (genvar gi = 0; gi < 32; gi++) begin : g_lane
    localparam int DEPTH = 31 - gi;
    if (DEPTH == 0) begin : g_direct
      assign w_aligned[gi] = acc_data_i[gi];
    end else begin : g_delay
      logic [31:0] r_dly [DEPTH];
      always_ff @(posedge clk_i) begin
        r_dly[0] <= acc_data_i[gi];
        for (int k = 1; k < DEPTH; k++) r_dly[k] <= r_dly[k-1];
      end
      assign w_aligned[gi] = r_dly[DEPTH-1];
    end
    assign w_quant[gi] = quant(w_aligned[gi], r_shift, r_relu);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_count   <= '0;
      r_ub_ptr  <= '0;
      r_shift   <= '0;
      r_relu    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_ub_addr <= '0;
      r_ub_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en   <= w_row_valid;
      r_ub_addr <= w_row_valid ? r_ub_ptr : '0;
      for (int j = 0; j < 32; j++) r_ub_data[j] <= w_row_valid ? w_quant[j] : 8'h00;
      if (w_row_valid) r_ub_ptr <= r_ub_ptr + UB_ADDR_W'(1);
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_count  <= row_count_i;
            r_ub_ptr <= ub_base_i;
            r_shift  <= shift_i;
            r_relu   <= relu_en_i;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            if (row_count_i == 8'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_READ;
              r_rd_en   <= 1'b1;
              r_rd_addr <= acc_base_i;
            end
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_last_rd) begin
            r_state   <= S_FLUSH;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + 7'd1;
          end
        end
        // The final row's write is on the outputs during this cycle.
        S_FLUSH: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign acc_rd_en_o   = r_rd_en;
  assign acc_addr_rd_o = r_rd_addr;
  assign ub_wr_en_o    = r_wr_en;
  assign ub_addr_o     = r_ub_addr;
  assign ub_data_o     = r_ub_data;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule

// File: tb/tb_accumulator_drain.sv
// Directed bench for accumulator_drain: a skewed accumulator read model feeds the DUT,
// each scenario task records one drain cycle by cycle and compares against hand values.
module tb_accumulator_drain;
  localparam int UBW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i, start_i, relu_en_i;
  logic [6:0]         acc_base_i;
  logic [7:0]         row_count_i;
  logic [UBW-1:0]     ub_base_i;
  logic [4:0]         shift_i;
  logic [31:0][31:0]  acc_data_i;
  logic               acc_rd_en_o, ub_wr_en_o, busy_o, done_o;
  logic [6:0]         acc_addr_rd_o;
  logic [UBW-1:0]     ub_addr_o;
  logic [31:0][7:0]   ub_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  int mem [128][32];

  logic             ob_rd   [256];
  logic [6:0]       ob_ra   [256];
  logic             ob_wr   [256];
  logic [UBW-1:0]   ob_wa   [256];
  logic [31:0][7:0] ob_wd   [256];
  logic             ob_busy [256];
  logic             ob_done [256];

  accumulator_drain #(.UB_ADDR_W(UBW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .acc_base_i   (acc_base_i),
    .row_count_i  (row_count_i),
    .ub_base_i    (ub_base_i),
    .shift_i      (shift_i),
    .relu_en_i    (relu_en_i),
    .acc_data_i   (acc_data_i),
    .acc_rd_en_o  (acc_rd_en_o),
    .acc_addr_rd_o(acc_addr_rd_o),
    .ub_wr_en_o   (ub_wr_en_o),
    .ub_addr_o    (ub_addr_o),
    .ub_data_o    (ub_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // Accumulator read port: lane j shows row (addr - j) mod 128, combinationally.
  always_comb begin
    for (int j = 0; j < 32; j++)
      acc_data_i[j] = 32'(mem[(int'(acc_addr_rd_o) - j) & 127][j]);
  end

  function automatic logic [7:0] ref_q(input int v, input int sh, input int relu);
    longint p, q;
    p = longint'(1) << sh;
    if (v >= 0) q = longint'(v) / p;
    else        q = -((-longint'(v) + p - 1) / p);
    if (relu != 0 && q < 0) q = 0;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  function automatic logic [31:0][7:0] ref_row(input int k, input int sh, input int relu);
    logic [31:0][7:0] r;
    for (int j = 0; j < 32; j++) r[j] = ref_q(mem[k & 127][j], sh, relu);
    return r;
  endfunction

  task automatic fill(input int a, input int b, input int m, input int off);
    for (int k = 0; k < 128; k++)
      for (int j = 0; j < 32; j++) mem[k][j] = ((k * a + j * b) % m) - off;
  endtask

  // Issues one command at the current negedge and records len cycles (cycle 0 = first read).
  // Command inputs are scrambled from cycle 1 on; optional start pulse / reset at given cycles.
  task automatic drain(input int base, input int n, input int ubb, input int sh, input int relu,
                       input int len, input int pulse_c, input int rst_c);
    acc_base_i  = 7'(base);
    row_count_i = 8'(n);
    ub_base_i   = UBW'(ubb);
    shift_i     = 5'(sh);
    relu_en_i   = (relu != 0);
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < len; c++) begin
      if (c == 1) begin
        acc_base_i  = 7'h55;
        row_count_i = 8'd2;
        ub_base_i   = ~ub_base_i;
        shift_i     = ~shift_i;
        relu_en_i   = ~relu_en_i;
      end
      start_i    = (c == pulse_c);
      rst_i      = (c == rst_c);
      ob_rd[c]   = acc_rd_en_o;
      ob_ra[c]   = acc_addr_rd_o;
      ob_wr[c]   = ub_wr_en_o;
      ob_wa[c]   = ub_addr_o;
      ob_wd[c]   = ub_data_o;
      ob_busy[c] = busy_o;
      ob_done[c] = done_o;
      @(negedge clk);
    end
    start_i = 1'b0;
    rst_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    start_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({acc_rd_en_o, acc_addr_rd_o, ub_wr_en_o, ub_addr_o, busy_o, done_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl got rd=%b ra=%0d wr=%b wa=%0d busy=%b done=%b required all 0",
               acc_rd_en_o, acc_addr_rd_o, ub_wr_en_o, ub_addr_o, busy_o, done_o);
    end
    n_cmp++;
    if (ub_data_o !== '0) begin
      n_bad++;
      $display("FAIL reset_data got=%h required 0", ub_data_o);
    end
    rst_i   = 1'b0;
    start_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy_o, acc_rd_en_o, done_o} !== 3'b000) begin
        n_bad++;
        $display("FAIL start_with_reset c=%0d got busy=%b rd=%b done=%b required 000",
                 c, busy_o, acc_rd_en_o, done_o);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0][7:0] e;
    logic             er, ew;
    int               v;
    fill(100, 1, 100000, 0);
    drain(0, 4, 0, 0, 0, 45, -1, -1);
    for (int c = 0; c < 45; c++) begin
      er = (c <= 34);
      ew = (c >= 32 && c <= 35);
      n_cmp++;
      if (ob_rd[c] !== er) begin
        n_bad++; $display("FAIL basic_rd_en c=%0d got=%b required=%b", c, ob_rd[c], er);
      end
      if (er) begin
        n_cmp++;
        if (ob_ra[c] !== 7'(c)) begin
          n_bad++; $display("FAIL basic_rd_addr c=%0d got=%0d required=%0d", c, ob_ra[c], c);
        end
      end
      n_cmp++;
      if (ob_wr[c] !== ew) begin
        n_bad++; $display("FAIL basic_wr_en c=%0d got=%b required=%b", c, ob_wr[c], ew);
      end
      if (ew) begin
        for (int j = 0; j < 32; j++) begin
          v = 100 * (c - 32) + j;
          e[j] = (v > 127) ? 8'd127 : 8'(v);
        end
        n_cmp++;
        if (ob_wa[c] !== UBW'(c - 32)) begin
          n_bad++; $display("FAIL basic_wr_addr c=%0d got=%0d required=%0d", c, ob_wa[c], c - 32);
        end
        n_cmp++;
        if (ob_wd[c] !== e) begin
          n_bad++; $display("FAIL basic_row%0d got=%h required=%h", c - 32, ob_wd[c], e);
        end
      end
      n_cmp++;
      if ({ob_busy[c], ob_done[c]} !== {(c <= 36), (c == 36)}) begin
        n_bad++;
        $display("FAIL basic_busy_done c=%0d got=%b%b required=%b%b", c, ob_busy[c], ob_done[c],
                 (c <= 36), (c == 36));
      end
    end
  endtask

  task automatic test_quantize();
    int       q_sh   [6] = '{3, 3, 4, 1, 3, 1};
    int       q_relu [6] = '{0, 1, 0, 0, 0, 1};
    int       q_lane [6] = '{0, 0, 1, 2, 3, 2};
    logic [7:0] q_exp [6] = '{8'h83, 8'h00, 8'h7f, 8'hfc, 8'h80, 8'h00};
    for (int k = 0; k < 128; k++)
      for (int j = 0; j < 32; j++) mem[k][j] = 0;
    mem[10][0] = -1000;
    mem[10][1] = 5000;
    mem[10][2] = -7;
    mem[10][3] = -2000;
    for (int t = 0; t < 6; t++) begin
      drain(10, 1, 3, q_sh[t], q_relu[t], 41, -1, -1);
      n_cmp++;
      if ({ob_wr[32], ob_wa[32], ob_done[33]} !== {1'b1, UBW'(3), 1'b1}) begin
        n_bad++;
        $display("FAIL quant%0d_strobe got wr=%b wa=%0d done=%b required wr=1 wa=3 done=1",
                 t, ob_wr[32], ob_wa[32], ob_done[33]);
      end
      n_cmp++;
      if (ob_wd[32][q_lane[t]] !== q_exp[t]) begin
        n_bad++;
        $display("FAIL quant%0d_lane%0d got=%h required=%h", t, q_lane[t],
                 ob_wd[32][q_lane[t]], q_exp[t]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0][7:0] e;
    logic             ew;
    fill(7, 13, 300, 150);
    drain(120, 16, 250, 0, 0, 60, -1, -1);
    for (int c = 0; c < 60; c++) begin
      n_cmp++;
      if (ob_rd[c] !== (c <= 46)) begin
        n_bad++; $display("FAIL wrap_rd_en c=%0d got=%b required=%b", c, ob_rd[c], (c <= 46));
      end
      if (c <= 46) begin
        n_cmp++;
        if (ob_ra[c] !== 7'((120 + c) % 128)) begin
          n_bad++;
          $display("FAIL wrap_rd_addr c=%0d got=%0d required=%0d", c, ob_ra[c], (120 + c) % 128);
        end
      end
      ew = (c >= 32 && c <= 47);
      n_cmp++;
      if (ob_wr[c] !== ew) begin
        n_bad++; $display("FAIL wrap_wr_en c=%0d got=%b required=%b", c, ob_wr[c], ew);
      end
      if (ew) begin
        e = ref_row(120 + c - 32, 0, 0);
        n_cmp++;
        if (ob_wa[c] !== UBW'((250 + c - 32) % 256)) begin
          n_bad++;
          $display("FAIL wrap_wr_addr c=%0d got=%0d required=%0d", c, ob_wa[c], (250 + c - 32) % 256);
        end
        n_cmp++;
        if (ob_wd[c] !== e) begin
          n_bad++; $display("FAIL wrap_row%0d got=%h required=%h", c - 32, ob_wd[c], e);
        end
      end
      n_cmp++;
      if (ob_done[c] !== (c == 48)) begin
        n_bad++; $display("FAIL wrap_done c=%0d got=%b required=%b", c, ob_done[c], (c == 48));
      end
    end
  endtask

  task automatic test_full();
    int reads, writes, dones;
    logic [31:0][7:0] e;
    fill(131, 17, 2000, 1000);
    drain(64, 128, 0, 2, 1, 175, 50, -1);
    reads = 0; writes = 0; dones = 0;
    for (int c = 0; c < 175; c++) begin
      if (ob_rd[c] === 1'b1) reads++;
      if (ob_done[c] === 1'b1) dones++;
      if (ob_wr[c] === 1'b1) begin
        e = ref_row(64 + writes, 2, 1);
        n_cmp++;
        if (c !== writes + 32 || ob_wa[c] !== UBW'(writes) || ob_wd[c] !== e) begin
          n_bad++;
          $display("FAIL full_write%0d c=%0d addr=%0d data=%h required c=%0d addr=%0d data=%h",
                   writes, c, ob_wa[c], ob_wd[c], writes + 32, writes, e);
        end
        writes++;
      end
    end
    n_cmp++;
    if (reads !== 159) begin
      n_bad++; $display("FAIL full_read_cycles got=%0d required=159", reads);
    end
    n_cmp++;
    if (writes !== 128) begin
      n_bad++; $display("FAIL full_write_count got=%0d required=128", writes);
    end
    n_cmp++;
    if ({ob_rd[158], ob_ra[158], ob_rd[159]} !== {1'b1, 7'd94, 1'b0}) begin
      n_bad++;
      $display("FAIL full_last_read got rd158=%b ra158=%0d rd159=%b required 1 94 0",
               ob_rd[158], ob_ra[158], ob_rd[159]);
    end
    n_cmp++;
    if (dones !== 1 || ob_done[160] !== 1'b1) begin
      n_bad++; $display("FAIL full_done got count=%0d at160=%b required 1 1", dones, ob_done[160]);
    end
    n_cmp++;
    if ({ob_busy[160], ob_busy[161], ob_busy[174]} !== 3'b100) begin
      n_bad++;
      $display("FAIL full_busy_end got=%b%b%b required=100", ob_busy[160], ob_busy[161], ob_busy[174]);
    end
  endtask

  task automatic test_zero_b2b();
    logic [31:0][7:0] e;
    drain(9, 0, 0, 0, 0, 4, -1, -1);
    n_cmp++;
    if ({ob_busy[0], ob_done[0], ob_busy[1], ob_done[1]} !== 4'b1100) begin
      n_bad++;
      $display("FAIL zero_done got b0=%b d0=%b b1=%b d1=%b required 1 1 0 0",
               ob_busy[0], ob_done[0], ob_busy[1], ob_done[1]);
    end
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({ob_rd[c], ob_wr[c]} !== 2'b00) begin
        n_bad++; $display("FAIL zero_strobes c=%0d got rd=%b wr=%b required 00", c, ob_rd[c], ob_wr[c]);
      end
    end
    fill(100, 1, 100000, 0);
    drain(3, 2, 5, 0, 0, 35, -1, -1);
    n_cmp++;
    if ({ob_done[34], ob_busy[34], ob_wr[33], ob_wa[33]} !== {1'b1, 1'b1, 1'b1, UBW'(6)}) begin
      n_bad++;
      $display("FAIL b2b_first got done=%b busy=%b wr33=%b wa33=%0d required 1 1 1 6",
               ob_done[34], ob_busy[34], ob_wr[33], ob_wa[33]);
    end
    drain(40, 1, 7, 1, 0, 41, -1, -1);
    n_cmp++;
    if ({ob_rd[0], ob_ra[0]} !== {1'b1, 7'd40}) begin
      n_bad++;
      $display("FAIL b2b_second_start got rd=%b ra=%0d required 1 40", ob_rd[0], ob_ra[0]);
    end
    e = ref_row(40, 1, 0);
    n_cmp++;
    if ({ob_wr[32], ob_wa[32], ob_wd[32], ob_done[33]} !== {1'b1, UBW'(7), e, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_second_write got wr=%b wa=%0d data=%h done=%b required 1 7 %h 1",
               ob_wr[32], ob_wa[32], ob_wd[32], ob_done[33], e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0][7:0] e;
    fill(100, 1, 100000, 0);
    drain(0, 20, 0, 0, 0, 70, -1, 40);
    n_cmp++;
    if ({ob_rd[39], ob_busy[40]} !== 2'b11) begin
      n_bad++; $display("FAIL rstmid_active got rd39=%b busy40=%b required 11", ob_rd[39], ob_busy[40]);
    end
    for (int c = 41; c < 70; c++) begin
      n_cmp++;
      if ({ob_rd[c], ob_ra[c], ob_wr[c], ob_wa[c], ob_wd[c], ob_busy[c], ob_done[c]} !== '0) begin
        n_bad++;
        $display("FAIL rstmid_quiet c=%0d got rd=%b wr=%b busy=%b done=%b data=%h required all 0",
                 c, ob_rd[c], ob_wr[c], ob_busy[c], ob_done[c], ob_wd[c]);
      end
    end
    drain(2, 3, 100, 2, 0, 43, -1, -1);
    for (int r = 0; r < 3; r++) begin
      e = ref_row(2 + r, 2, 0);
      n_cmp++;
      if ({ob_wr[32 + r], ob_wa[32 + r], ob_wd[32 + r]} !== {1'b1, UBW'(100 + r), e}) begin
        n_bad++;
        $display("FAIL rstmid_fresh_row%0d got wr=%b wa=%0d data=%h required 1 %0d %h",
                 r, ob_wr[32 + r], ob_wa[32 + r], ob_wd[32 + r], 100 + r, e);
      end
    end
    n_cmp++;
    if ({ob_wr[35], ob_done[35], ob_busy[36]} !== 3'b010) begin
      n_bad++;
      $display("FAIL rstmid_fresh_done got wr35=%b done35=%b busy36=%b required 010",
               ob_wr[35], ob_done[35], ob_busy[36]);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    acc_base_i  = '0;
    row_count_i = '0;
    ub_base_i   = '0;
    shift_i     = '0;
    relu_en_i   = 1'b0;
    for (int k = 0; k < 128; k++)
      for (int j = 0; j < 32; j++) mem[k][j] = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_quantize();
    test_wrap();
    test_full();
    test_zero_b2b();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
